// File: rtl/rk16_pkg.sv
// Shared RK16 definitions: stage one-hot codes, opcodes and the fetch sequencer state set.
package rk16_pkg;

  localparam logic [3:0] STG_NONE = 4'b0000;
  localparam logic [3:0] STG0     = 4'b0001;
  localparam logic [3:0] STG1     = 4'b0010;
  localparam logic [3:0] STG2     = 4'b0100;
  localparam logic [3:0] STG3     = 4'b1000;

  localparam logic [3:0] CALC  = 4'h0;
  localparam logic [3:0] CALCI = 4'h1;
  localparam logic [3:0] LOAD  = 4'h2;
  localparam logic [3:0] STORE = 4'h3;
  localparam logic [3:0] CALIF = 4'h4;

  typedef enum logic [2:0] {
    FS_FETCH  = 3'd0,
    FS_STG0   = 3'd1,
    FS_STG1   = 3'd2,
    FS_STG2   = 3'd3,
    FS_STG3   = 3'd4,
    FS_HALTED = 3'd5
  } fs_state_e;

endpackage

// File: rtl/pc_unit.sv
// Program counter with increment/target select; ret_addr is the sequential successor.
module pc_unit #(
  parameter int unsigned       PC_W   = 16,
  parameter logic [PC_W-1:0]   RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            take,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] ret_addr
);

  logic [PC_W-1:0] pc_q, pc_d;

  assign ret_addr = pc_q + PC_W'(1);

  always_comb begin
    pc_d = pc_q;
    if (load) pc_d = take ? target : ret_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RST_PC;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_seq.sv
// RK16 front end: fetches one instruction per slot, sequences STG0..STG3,
// resolves CALIF at STG3 exit and supports debug halt/single-step.
module fetch_seq
  import rk16_pkg::*;
#(
  parameter int unsigned     PC_W   = 16,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [3:0]      stage,
  input  logic            pfc_ctrl,
  input  logic            cond,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] ret_addr,
  output logic [PC_W-1:0] pc,
  input  logic            halt,
  input  logic            step,
  output logic            halted,
  output logic [15:0]     instret
);

  fs_state_e   state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] inst_q;
  logic [15:0] instret_q;
  logic        retire;
  logic        fetch_done;

  assign fetch_done = (state_q == FS_FETCH) && req_q && imem_ack;

  // req is registered so it stays low for the first cycle after reset
  // release, then rises together with every entry into FETCH.
  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      FS_FETCH: begin
        if (fetch_done) state_d = FS_STG0;
        else            req_d   = 1'b1;
      end
      FS_STG0: state_d = FS_STG1;
      FS_STG1: state_d = FS_STG2;
      FS_STG2: state_d = FS_STG3;
      FS_STG3: begin
        retire = 1'b1;
        if (halt && !step) begin
          state_d = FS_HALTED;
        end else begin
          state_d = FS_FETCH;
          req_d   = 1'b1;
        end
      end
      FS_HALTED: begin
        if (step || !halt) begin
          state_d = FS_FETCH;
          req_d   = 1'b1;
        end
      end
      default: state_d = FS_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FS_FETCH;
      req_q     <= 1'b0;
      inst_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      if (fetch_done) inst_q    <= imem_rdata;
      if (retire)     instret_q <= instret_q + 16'd1;
    end
  end

  always_comb begin
    unique case (state_q)
      FS_STG0: stage = STG0;
      FS_STG1: stage = STG1;
      FS_STG2: stage = STG2;
      FS_STG3: stage = STG3;
      default: stage = STG_NONE;
    endcase
  end

  pc_unit #(
    .PC_W   (PC_W),
    .RST_PC (RST_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (retire),
    .take     (pfc_ctrl && cond),
    .target   (target),
    .pc       (pc),
    .ret_addr (ret_addr)
  );

  assign imem_req  = req_q;
  assign imem_addr = pc;
  assign inst      = inst_q;
  assign halted    = (state_q == FS_HALTED);
  assign instret   = instret_q;

endmodule
